// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice: FSM states, default
// widths and requester indices.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: on contention the requester that
// did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || last_grant)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port data memory.
// Optional alignment checking with err output: define DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  output logic              err,
`endif
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state;
  logic              last_grant;
  logic              owner;
  logic              lat_we;
  logic [1:0]        gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_ok;
  logic [DATA_W-1:0] rd_word;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign m0_gnt    = (state == IDLE) && gnt[0];
  assign m1_gnt    = (state == IDLE) && gnt[1];
  assign win_we    = gnt[1] ? m1_we    : m0_we;
  assign win_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign win_wdata = gnt[1] ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic misaligned;
  // mem_addr holds the latched address, so it is the one checked in ACCESS.
  assign misaligned = (mem_addr[1:0] != 2'b00);
  assign win_ok     = (win_addr[1:0] == 2'b00);
  assign rd_word    = misaligned ? '0 : mem_rdata;
`else
  assign win_ok     = 1'b1;
  assign rd_word    = mem_rdata;
`endif

  // mem_write is set on entry to ACCESS so it is high for exactly that cycle
  // and drops immediately on asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= REQ_LSU;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      mem_write <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner      <= gnt[1];
            last_grant <= gnt[1];
            lat_we     <= win_we;
            mem_addr   <= win_addr;
            mem_wdata  <= win_wdata;
            mem_write  <= win_we && win_ok;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_we) begin
            if (owner == REQ_DBG) m1_rdata <= rd_word;
            else                  m0_rdata <= rd_word;
          end
          if (owner == REQ_DBG) m1_done <= 1'b1;
          else                  m0_done <= 1'b1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          err <= misaligned;
`endif
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
